// File: rtl/led_bank_pkg.sv
// led_bank shared types and constants.
// Mode encoding, reset defaults and small helpers.
package led_bank_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  localparam int unsigned DEFAULT_PERIOD_C = 50000;
  localparam led_mode_t   RESET_MODE_C     = LED_BLINK;

  function automatic int unsigned ch_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // led level a channel takes when its phase
  // restarts (config write or sync)
  function automatic logic fresh_led(
    input led_mode_t m,
    input logic      duty_nz
  );
    return (m == LED_ON) ||
           ((m == LED_PWM) && duty_nz);
  endfunction

endpackage

// File: rtl/led_bank_if.sv
// led_bank configuration bus and led outputs.
// master: cfg_we/cfg_ch/cfg_mode/cfg_period/cfg_duty/sync out, led in.
interface led_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DUTY_W   = 8
) ();
  import led_bank_pkg::*;

  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  led_mode_t           cfg_mode;
  logic [CNT_W-1:0]    cfg_period;
  logic [DUTY_W-1:0]   cfg_duty;
  logic                sync;
  logic [CHANNELS-1:0] led;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    output cfg_duty,
    output sync,
    input  led
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_period,
    input  cfg_duty,
    input  sync,
    output led
  );

endinterface

// File: rtl/led_bank_channel.sv
// One led_bank channel: config, divider, PWM step and led register.
// Ports: clk, rst_n, i_we, i_sync, i_mode, i_period, i_duty -> o_led.
// LED_BANK_PWM_EN adds duty register and pwm counter; otherwise PWM = OFF.
module led_bank_channel
  import led_bank_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DUTY_W         = 8,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C,
  parameter led_mode_t   RESET_MODE     = RESET_MODE_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_sync,
  input  led_mode_t         i_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_led
);

  led_mode_t        r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_div;
  logic             r_led;

  logic w_wrap;
  logic w_restart;
  logic w_led_nxt;
  logic w_pwm_led;
  logic w_wr_duty_nz;
  logic w_cur_duty_nz;

  assign w_wrap    = (r_div == r_period);
  assign w_restart = i_we | i_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= RESET_MODE;
      r_period <= CNT_W'(DEFAULT_PERIOD);
    end else if (i_we) begin
      r_mode   <= i_mode;
      r_period <= i_period;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_restart || w_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + CNT_W'(1);
    end
  end

`ifdef LED_BANK_PWM_EN
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_pwm;
  logic [DUTY_W-1:0] w_pwm_nxt;

  // pwm wraps naturally at 2^DUTY_W
  assign w_pwm_nxt = w_wrap ?
                     r_pwm + DUTY_W'(1) : r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_pwm  <= '0;
    end else if (i_we) begin
      r_duty <= i_duty;
      r_pwm  <= '0;
    end else if (i_sync) begin
      r_pwm  <= '0;
    end else begin
      r_pwm  <= w_pwm_nxt;
    end
  end

  assign w_pwm_led     = (w_pwm_nxt < r_duty);
  assign w_wr_duty_nz  = |i_duty;
  assign w_cur_duty_nz = |r_duty;
`else
  logic w_unused_duty;

  assign w_unused_duty = ^i_duty;
  assign w_pwm_led     = 1'b0;
  assign w_wr_duty_nz  = 1'b0;
  assign w_cur_duty_nz = 1'b0;
`endif

  always_comb begin
    w_led_nxt = 1'b0;
    if (i_we) begin
      w_led_nxt = fresh_led(i_mode, w_wr_duty_nz);
    end else if (i_sync) begin
      w_led_nxt = fresh_led(r_mode, w_cur_duty_nz);
    end else begin
      unique case (r_mode)
        LED_OFF:   w_led_nxt = 1'b0;
        LED_ON:    w_led_nxt = 1'b1;
        LED_BLINK: w_led_nxt = r_led ^ w_wrap;
        LED_PWM:   w_led_nxt = w_pwm_led;
        default:   w_led_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver: OFF/ON/BLINK/PWM per channel.
// Ports: clk, rst_n, bus (led_bank_if.slave); macro LED_BANK_PWM_EN.
module led_bank
  import led_bank_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DUTY_W         = 8,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C,
  parameter led_mode_t   RESET_MODE     = RESET_MODE_C
) (
  input  logic       clk,
  input  logic       rst_n,
  led_bank_if.slave  bus
);

  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic [CH_W:0]         w_ch_ext;
  logic                  w_ch_hit;
  logic [CHANNELS-1:0]   w_we;
  logic [CHANNELS-1:0]   w_led;

  // out-of-range indices must not alias onto a
  // real channel, so compare with one spare bit
  assign w_ch_ext = {1'b0, bus.cfg_ch};
  assign w_ch_hit = bus.cfg_we &&
                    (w_ch_ext < (CH_W+1)'(CHANNELS));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_we[i] = w_ch_hit &&
                     (bus.cfg_ch == CH_W'(i));

    led_bank_channel #(
      .CNT_W          (CNT_W),
      .DUTY_W         (DUTY_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .RESET_MODE     (RESET_MODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_we[i]),
      .i_sync   (bus.sync),
      .i_mode   (bus.cfg_mode),
      .i_period (bus.cfg_period),
      .i_duty   (bus.cfg_duty),
      .o_led    (w_led[i])
    );
  end

  assign bus.led = w_led;

endmodule

// File: tb/tb_led_bank.sv
// led_bank bench: vector table plus hand sequences.
// Second instance with default parameters checks the 50001-edge rise.
`timescale 1ns/1ps
module tb_led_bank;
  import led_bank_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 32;
  localparam int DW  = 8;
  localparam int TP  = 20;
`ifdef LED_BANK_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst_nd = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   ed     = 0;

  always #5 clk = ~clk;

  led_bank_if #(
    .CHANNELS(NCH), .CNT_W(CW), .DUTY_W(DW)
  ) bus ();
  led_bank_if busd ();

  led_bank #(
    .CHANNELS       (NCH),
    .CNT_W          (CW),
    .DUTY_W         (DW),
    .DEFAULT_PERIOD (TP),
    .RESET_MODE     (LED_BLINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  led_bank dut_d (
    .clk   (clk),
    .rst_n (rst_nd),
    .bus   (busd)
  );

  always @(posedge clk) begin
    if (!rst_nd) ed <= 0;
    else         ed <= ed + 1;
  end

  typedef struct {
    logic [NCH-1:0] exp;
    logic [NCH-1:0] msk;
    string          nm;
  } sb_t;

  typedef struct {
    logic        we;
    logic [2:0]  ch;
    led_mode_t   mode;
    logic [31:0] per;
    logic [7:0]  duty;
    logic        sy;
    logic [4:0]  exp;
    logic [4:0]  msk;
    string       nm;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[15];

  task automatic chk(
    input logic [31:0] act,
    input logic [31:0] exp,
    input string       nm
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic        we,
    input logic [2:0]  ch,
    input led_mode_t   m,
    input logic [31:0] p,
    input logic [7:0]  d,
    input logic        sy
  );
    bus.cfg_we     = we;
    bus.cfg_ch     = ch;
    bus.cfg_mode   = m;
    bus.cfg_period = p;
    bus.cfg_duty   = d;
    bus.sync       = sy;
  endtask

  task automatic tick(
    input logic [NCH-1:0] exp,
    input logic [NCH-1:0] msk,
    input string          nm
  );
    sb_t e;
    sbq.push_back('{exp, msk, nm});
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    bus.sync   = 1'b0;
    e = sbq.pop_front();
    chk(32'(bus.led & e.msk),
        32'(e.exp & e.msk), e.nm);
  endtask

  initial begin
    logic [NCH-1:0] x;
    int guard;

    vt[0]  = '{1, 0, LED_ON,    3, 0, 0,
               5'b00001, 5'b00001, "w0_on"};
    vt[1]  = '{1, 0, LED_OFF,   3, 0, 0,
               5'b00000, 5'b00001, "w0_off"};
    vt[2]  = '{1, 1, LED_ON,    7, 0, 0,
               5'b00010, 5'b00011, "w1_on"};
    vt[3]  = '{1, 2, LED_OFF,   7, 0, 0,
               5'b00010, 5'b00111, "w2_off"};
    vt[4]  = '{1, 3, LED_ON,    0, 0, 0,
               5'b01010, 5'b01111, "w3_on"};
    vt[5]  = '{1, 4, LED_OFF,   0, 0, 0,
               5'b01010, 5'b11111, "w4_off"};
    vt[6]  = '{1, 5, LED_OFF,   0, 0, 0,
               5'b01010, 5'b11111, "w5_ign"};
    vt[7]  = '{1, 6, LED_ON,    0, 0, 0,
               5'b01010, 5'b11111, "w6_ign"};
    vt[8]  = '{1, 7, LED_OFF,   0, 0, 0,
               5'b01010, 5'b11111, "w7_ign"};
    vt[9]  = '{0, 0, LED_OFF,   0, 0, 1,
               5'b01010, 5'b11111, "sync_static"};
    vt[10] = '{0, 0, LED_ON,    0, 0, 0,
               5'b01010, 5'b11111, "idle"};
    vt[11] = '{1, 4, LED_ON,    0, 0, 0,
               5'b11010, 5'b11111, "w4_on"};
    vt[12] = '{1, 4, LED_PWM,   0, 0, 0,
               5'b01010, 5'b11111, "w4_pwm0"};
    vt[13] = '{1, 4, LED_PWM,   5, 1, 0,
               {PWM, 4'b1010}, 5'b11111, "w4_pwm1"};
    vt[14] = '{1, 4, LED_OFF,   5, 1, 0,
               5'b01010, 5'b11111, "w4_off2"};

    drive(0, 0, LED_OFF, 0, 0, 0);
    busd.cfg_we     = 1'b0;
    busd.cfg_ch     = '0;
    busd.cfg_mode   = LED_OFF;
    busd.cfg_period = '0;
    busd.cfg_duty   = '0;
    busd.sync       = 1'b0;

    #2;
    chk(32'(bus.led), 0, "rst_led");
    chk(32'(busd.led), 0, "rst_led_d");
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst_nd = 1'b1;

    // reset-default blink, level lasts TP+1
    for (int e = 1; e <= 2*(TP+1); e++) begin
      x = (e >= TP+1 && e < 2*(TP+1)) ? '1 : '0;
      tick(x, '1, "dflt_blink");
    end

    // async reset in the middle of a high level
    repeat (25) @(posedge clk);
    tick('1, '1, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk(32'(bus.led), 0, "async_clr");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= TP+1; e++) begin
      x = (e == TP+1) ? '1 : '0;
      tick(x, '1, "rst_restart");
    end

    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].ch, vt[i].mode,
            vt[i].per, vt[i].duty, vt[i].sy);
      tick(vt[i].exp, vt[i].msk, vt[i].nm);
    end

    // ch2 BLINK period 3
    drive(1, 2, LED_BLINK, 3, 0, 0);
    tick(5'b01010, '1, "w2_blink");
    for (int e = 1; e <= 12; e++) begin
      x = 5'b01010;
      x[2] = ((e/4) % 2 == 1);
      tick(x, '1, "blink3");
    end

    // ch1 PWM period 0 duty 64 / 0 / 255
    drive(1, 1, LED_PWM, 0, 64, 0);
    tick({3'b010, PWM, 1'b0}, 5'b11011, "w1_pwm64");
    for (int e = 1; e < 512; e++) begin
      x = 5'b01000;
      x[1] = PWM && ((e % 256) < 64);
      tick(x, 5'b11011, "pwm64");
    end
    drive(1, 1, LED_PWM, 0, 0, 0);
    tick(5'b01000, 5'b11011, "w1_pwm0");
    for (int e = 1; e <= 300; e++) begin
      tick(5'b01000, 5'b11011, "pwm0");
    end
    drive(1, 1, LED_PWM, 0, 255, 0);
    tick({3'b010, PWM, 1'b0}, 5'b11011, "w1_pwm255");
    for (int e = 1; e <= 300; e++) begin
      x = 5'b01000;
      x[1] = PWM && ((e % 256) != 255);
      tick(x, 5'b11011, "pwm255");
    end

    // sync together with a write to ch3
    drive(1, 0, LED_BLINK, 2, 0, 0);
    tick(5'b00000, 5'b00001, "w0_blink2");
    drive(1, 3, LED_BLINK, 5, 0, 0);
    tick(5'b00000, 5'b01000, "w3_blink5");
    repeat (7) @(posedge clk);
    #1;
    drive(1, 3, LED_BLINK, 1, 0, 1);
    tick({3'b000, PWM, 1'b0}, '1, "sync_wr");
    for (int e = 1; e <= 12; e++) begin
      x = '0;
      x[0] = ((e/3) % 2 == 1);
      x[1] = PWM;
      x[2] = ((e/4) % 2 == 1);
      x[3] = ((e/2) % 2 == 1);
      tick(x, '1, "sync_phase");
    end

    // default instance: rise after edge 50001
    guard = 0;
    while (ed < 50000 && guard < 60000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk(32'(ed), 50000, "d_wait");
    chk(32'(busd.led), 0, "d_edge50000");
    @(posedge clk);
    #1;
    chk(32'(busd.led), 32'hf, "d_edge50001");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/led_bank.md
# led_bank

Parametrised multi-channel LED driver; next generation of the single-LED fixed-divisor blinker. Drives CHANNELS independent LED outputs. Each channel is run-time configurable to OFF, ON, BLINK (programmable half-period) or PWM (programmable duty). Sits between the board LED pins and any control logic or register interface that writes channel configuration.

## Interface
- CHANNELS, 4, number of LED channels (1..32)
- CNT_W, 32, width of per-channel period divider
- DUTY_W, 8, PWM resolution in bits
- DEFAULT_PERIOD, 50000, period loaded into every channel at reset
- RESET_MODE, 2 (BLINK), mode loaded into every channel at reset
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe, one cycle per write
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel index
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
- cfg_period  in  CNT_W  divider terminal count
- cfg_duty  in  DUTY_W  PWM on-count
- sync  in  1  restart all channels' phase simultaneously
- led  out  CHANNELS  registered LED drive, bit i = channel i

## Operation
- Per channel state: mode, period, duty, divider counter div (CNT_W), PWM step counter pwm (DUTY_W), led bit.
- Divider: every cycle, if div == period then div <= 0 and a wrap event fires; otherwise div <= div+1. Period 0 gives a wrap every cycle. Arithmetic is unsigned; div never exceeds period.
- OFF: led=0. ON: led=1. Divider keeps running; its output is ignored.
- BLINK: led toggles on each wrap, so each level lasts period+1 cycles.
- PWM: each wrap increments pwm (wraps at 2^DUTY_W-1 -> 0). led <= (pwm_next < duty), where pwm_next is the value pwm takes in that cycle. Duty 0 gives constant 0. Duty 2^DUTY_W-1 gives on for 255 of every 256 steps (DUTY_W=8).
- Write: when cfg_we=1 and cfg_ch < CHANNELS, that channel latches mode/period/duty. In the same cycle it clears div and pwm and sets led <= (cfg_mode==ON), or (cfg_mode==PWM && cfg_duty!=0). Writes with cfg_ch >= CHANNELS are ignored.
- sync: clears div and pwm of all channels and sets led to the fresh-write value for the current mode. Configuration is unchanged.
- Priority per channel: rst_n low > cfg_we hit > sync > normal counting.

## Timing
- Reset (async assert, sync release): led=0 all bits; mode=RESET_MODE, period=DEFAULT_PERIOD, duty=0, div=0, pwm=0.
- After reset release with defaults, led rises at the edge where div reaches DEFAULT_PERIOD, i.e. after the 50001st clock edge. It then toggles every 50001 cycles.
- Write latency: configuration and led take their new values at the edge that samples cfg_we. For BLINK, the first toggle comes period+1 edges later.
- Reset asserted mid-count aborts immediately; no partial state survives.
- Write and sync in the same cycle: the written channel takes write behaviour; all other channels take sync behaviour.

## Configuration
- LED_BANK_PWM_EN defined: PWM mode, the duty registers and the pwm counters are present.
- Undefined: duty registers and pwm counters are removed. Mode 3 is stored but behaves as OFF (led=0). cfg_duty is ignored. Port list is unchanged.

## Structure
- Package led_bank_pkg holds:
  - led_mode_t enum (LED_OFF, LED_ON, LED_BLINK, LED_PWM, 2 bits)
  - default DEFAULT_PERIOD and RESET_MODE constants
- Sub-module led_bank_channel holds one channel's state, divider, PWM and led register. Instantiate it CHANNELS times via generate. The top module decodes cfg_ch into per-channel write enables.

## Test plan
- Reset with defaults, CHANNELS=4 -> all led=0. Bit 0 rises after exactly 50001 edges, falls 50001 edges later, and all bits match.
- Write ch2 BLINK period=3 -> led[2]=0 at the write edge, then toggles every 4 cycles; other channels undisturbed.
- Write ch1 PWM period=0 duty=64 (DUTY_W=8) -> led[1] high 64 of every 256 cycles. Duty 0 -> constantly 0. Without LED_BANK_PWM_EN -> constantly 0.
- Write ch0 ON, then OFF -> led[0]=1 at the first write edge, 0 at the second. Write with cfg_ch=5 -> no channel changes.
- Channels 0/3 BLINK with periods 2/5, pulse sync; same cycle write ch3 period=1 -> ch0 restarts phase (led 0, toggle after 3 cycles), ch3 takes the period-1 write.
- Assert rst_n low mid-blink for 1 cycle, asynchronously -> led clears immediately, defaults are restored, and the 50001-cycle sequence restarts.
